// File: rtl/conv_relu_pool_if.sv
// Bus bundle for conv_relu_pool: map start, paired conv-sum beats and the pooled-pixel write port.
interface conv_relu_pool_if #(
  parameter int SUM_W  = 16,
  parameter int ADDR_W = 10
);
  logic                     i_start;
  logic [ADDR_W-1:0]        i_base_addr;
  logic                     i_valid;
  logic signed [SUM_W-1:0]  i_sum1;
  logic signed [SUM_W-1:0]  i_sum2;
  logic                     o_busy;
  logic                     o_wr_en;
  logic [ADDR_W-1:0]        o_wr_addr;
  logic [7:0]               o_wr_data;
  logic                     o_done;

  modport master (
    output i_start, i_base_addr, i_valid, i_sum1, i_sum2,
    input  o_busy, o_wr_en, o_wr_addr, o_wr_data, o_done
  );

  modport slave (
    input  i_start, i_base_addr, i_valid, i_sum1, i_sum2,
    output o_busy, o_wr_en, o_wr_addr, o_wr_data, o_done
  );
endinterface

// File: rtl/conv_relu_pool.sv
// ReLU + 2x2/stride-2 max pool + requantisation to u8 of paired conv sums,
// writing pooled pixels to sequential feature-map addresses.
module conv_relu_pool #(
  parameter int OUT_W  = 26,
  parameter int OUT_H  = 26,
  parameter int SUM_W  = 16,
  parameter int SHIFT  = 4,
  parameter int ADDR_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  conv_relu_pool_if.slave  bus
);
  localparam int COLS  = OUT_W / 2;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

  state_t                  r_state, w_next_state;
  logic [COL_W-1:0]        r_col;
  logic [ROW_W-1:0]        r_row;
  logic [ADDR_W-1:0]       r_addr;
  logic signed [SUM_W-1:0] r_line_buf [COLS];
  logic                    r_busy, r_wr_en, r_done;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [7:0]              r_wr_data;

  logic                    w_start_acc, w_lb_we, w_write, w_beat;
  logic                    w_last_col, w_last_row;
  logic signed [SUM_W-1:0] w_pair_max, w_pool_max, w_relu, w_shifted;
  logic [7:0]              w_quant;

  function automatic logic signed [SUM_W-1:0] max_signed(
    input logic signed [SUM_W-1:0] a,
    input logic signed [SUM_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_last_row = (r_row == ROW_W'(OUT_H - 1));
  assign w_beat     = w_lb_we | w_write;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_lb_we      = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      IDLE: if (bus.i_start) begin
        w_next_state = EVEN_ROW;
        w_start_acc  = 1'b1;
      end
      EVEN_ROW: if (bus.i_valid) begin
        w_lb_we = 1'b1;
        if (w_last_col) w_next_state = ODD_ROW;
      end
      ODD_ROW: if (bus.i_valid) begin
        w_write = 1'b1;
        if (w_last_col) w_next_state = w_last_row ? IDLE : EVEN_ROW;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_pair_max = max_signed(bus.i_sum1, bus.i_sum2);
    w_pool_max = max_signed(w_pair_max, r_line_buf[r_col]);
    w_relu     = (w_pool_max < 0) ? '0 : w_pool_max;
    w_shifted  = w_relu >>> SHIFT;
    w_quant    = (w_shifted > SUM_W'(255)) ? 8'hFF : w_shifted[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (w_start_acc) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= bus.i_base_addr;
    end else begin
      if (w_beat) r_col <= w_last_col ? '0 : r_col + 1'b1;
      if (w_beat && w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
      if (w_write) r_addr <= r_addr + 1'b1;
    end
  end

  // NOTE: the line buffer is plain storage with no reset; even rows always refill it before use.
  always_ff @(posedge i_clk) begin
    if (w_lb_we) r_line_buf[r_col] <= w_pair_max;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_write;
      r_done  <= w_write && w_last_col && w_last_row;
      if (w_write) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_quant;
      end
      // A start in the done cycle must keep busy high, so it wins over the clear.
      if (w_start_acc) r_busy <= 1'b1;
      else if (r_done) r_busy <= 1'b0;
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_wr_en   = r_wr_en;
  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_done    = r_done;
endmodule

// File: tb/tb_conv_relu_pool.sv
// Scoreboard bench for conv_relu_pool: a behavioural model queues expected writes as beats are driven.
module tb_conv_relu_pool;
  localparam int OUT_W  = 26;
  localparam int OUT_H  = 26;
  localparam int SUM_W  = 16;
  localparam int SHIFT  = 4;
  localparam int ADDR_W = 10;
  localparam int COLS   = OUT_W / 2;
  localparam int BEATS  = COLS * OUT_H;
  localparam int WRITES = COLS * (OUT_H / 2);

  typedef struct {
    int addr;
    int data;
    bit done;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_relu_pool_if #(.SUM_W(SUM_W), .ADDR_W(ADDR_W)) bus ();

  conv_relu_pool #(
    .OUT_W(OUT_W), .OUT_H(OUT_H), .SUM_W(SUM_W), .SHIFT(SHIFT), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  wr_t                     exp_q [$];
  int                      n_checks = 0;
  int                      n_fails  = 0;
  int                      n_wr     = 0;
  logic signed [SUM_W-1:0] b1 [BEATS];
  logic signed [SUM_W-1:0] b2 [BEATS];
  int                      m_lb [COLS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every write the DUT makes must be the next expected one; done only ever rides on a write.
  always @(negedge clk) begin
    if (rst_n) begin
      check("done_only_with_wr", {31'd0, bus.o_done & ~bus.o_wr_en}, 32'd0);
      if (bus.o_wr_en) begin
        wr_t e;
        n_wr++;
        check("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", {22'd0, bus.o_wr_addr}, e.addr);
          check("wr_data", {24'd0, bus.o_wr_data}, e.data);
          check("wr_done", {31'd0, bus.o_done}, {31'd0, e.done});
        end
      end
    end
  end

  task automatic fill_uniform(input int v);
    for (int k = 0; k < BEATS; k++) begin
      b1[k] = SUM_W'(v);
      b2[k] = SUM_W'(v);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < BEATS; k++) begin
      b1[k] = SUM_W'($urandom_range(0, 65535));
      b2[k] = SUM_W'($urandom_range(0, 65535));
    end
  endtask

  // Starts a map (with a simultaneous beat that must be dropped) and drives n_beats beats.
  task automatic run_map(input int base, input int gap_pct, input int glitch_beat, input int n_beats);
    int widx, col, row, pair, m, r, q;
    wr_t e;
    widx = 0;
    bus.i_start     = 1'b1;
    bus.i_base_addr = ADDR_W'(base);
    bus.i_valid     = 1'b1;
    bus.i_sum1      = 16'sh7FFF;
    bus.i_sum2      = 16'sh7FFF;
    tick();
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    check("busy_after_start", {31'd0, bus.o_busy}, 32'd1);
    for (int k = 0; k < n_beats; k++) begin
      col = k % COLS;
      row = k / COLS;
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.i_valid = 1'b0;
        bus.i_sum1  = SUM_W'($urandom_range(0, 65535));
        bus.i_sum2  = SUM_W'($urandom_range(0, 65535));
        tick();
      end
      bus.i_valid = 1'b1;
      bus.i_sum1  = b1[k];
      bus.i_sum2  = b2[k];
      bus.i_start = (k == glitch_beat);
      if (k == glitch_beat) bus.i_base_addr = '0;
      pair = (int'(b1[k]) > int'(b2[k])) ? int'(b1[k]) : int'(b2[k]);
      if (row % 2 == 0) begin
        m_lb[col] = pair;
      end else begin
        m = (pair > m_lb[col]) ? pair : m_lb[col];
        r = (m < 0) ? 0 : m;
        q = r / (1 << SHIFT);
        e.addr = (base + widx) % (1 << ADDR_W);
        e.data = (q > 255) ? 255 : q;
        e.done = (widx == WRITES - 1);
        exp_q.push_back(e);
        widx++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
  endtask

  // Called right after the last beat: the next cycle carries done, busy drops one cycle later.
  task automatic finish_map(input string tag);
    check({tag, "_busy_in_done_cycle"}, {31'd0, bus.o_busy}, 32'd1);
    tick();
    check({tag, "_busy_after_done"}, {31'd0, bus.o_busy}, 32'd0);
    check({tag, "_write_count"}, n_wr, WRITES);
    check({tag, "_sb_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic full_map(input string tag, input int base, input int gap_pct, input int glitch_beat);
    n_wr = 0;
    run_map(base, gap_pct, glitch_beat, BEATS);
    finish_map(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_base_addr = '0;
    bus.i_valid = 1'b0;
    bus.i_sum1 = '0;
    bus.i_sum2 = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      bus.i_start     = 1'($urandom_range(0, 1));
      bus.i_valid     = 1'($urandom_range(0, 1));
      bus.i_base_addr = ADDR_W'($urandom_range(0, 1023));
      bus.i_sum1      = SUM_W'($urandom_range(0, 65535));
      bus.i_sum2      = SUM_W'($urandom_range(0, 65535));
      tick();
    end
    check("rst_busy",    {31'd0, bus.o_busy},    32'd0);
    check("rst_wr_en",   {31'd0, bus.o_wr_en},   32'd0);
    check("rst_wr_addr", {22'd0, bus.o_wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, bus.o_wr_data}, 32'd0);
    check("rst_done",    {31'd0, bus.o_done},    32'd0);
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Beats without a start are ignored.
    for (int i = 0; i < 20; i++) begin
      bus.i_valid = 1'b1;
      bus.i_sum1  = SUM_W'($urandom_range(0, 65535));
      bus.i_sum2  = SUM_W'($urandom_range(0, 65535));
      tick();
    end
    bus.i_valid = 1'b0;
    tick();
    check("idle_valid_busy", {31'd0, bus.o_busy}, 32'd0);
    check("idle_valid_writes", n_wr, 32'd0);

    fill_uniform(256);
    full_map("uniform", 100, 0, -1);

    fill_uniform(0);
    b1[0] = 16'sd160;  b2[0] = 16'sd480;
    b1[COLS] = 16'sd800; b2[COLS] = 16'sd320;
    full_map("pool_sel", 7, 0, -1);

    fill_uniform(-5);
    full_map("negative", 20, 0, -1);

    fill_uniform(32'h7FFF);
    full_map("sat_max", 0, 0, -1);
    fill_uniform(4095);
    full_map("sat_4095", 300, 0, -1);
    fill_uniform(4080);
    full_map("sat_4080", 400, 0, -1);
    fill_uniform(4079);
    full_map("sat_4079", 500, 0, -1);

    // Same random map with and without gaps; base near the top to exercise address wrap.
    fill_random();
    full_map("rand_gapless", 1000, 0, -1);
    full_map("rand_gaps", 1000, 30, 150);

    // Reset mid-map after exactly 50 writes.
    fill_uniform(256);
    n_wr = 0;
    run_map(100, 0, -1, 3 * OUT_W + 11 + COLS);
    tick();
    check("midmap_writes_before_rst", n_wr, 32'd50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("midmap_rst_busy",  {31'd0, bus.o_busy},  32'd0);
    check("midmap_rst_wr_en", {31'd0, bus.o_wr_en}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.i_valid = 1'b1;
      bus.i_sum1  = 16'sd1000;
      bus.i_sum2  = 16'sd1000;
      tick();
    end
    bus.i_valid = 1'b0;
    check("post_rst_no_start_busy", {31'd0, bus.o_busy}, 32'd0);
    fill_random();
    full_map("after_rst", 500, 0, -1);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/conv_relu_pool.md
# conv_relu_pool

Downstream stage of the 3x3 convolution engine. It consumes the engine's paired outputs (two horizontally adjacent signed sums per beat) and applies ReLU, 2x2/stride-2 max pooling and requantisation to unsigned 8-bit. It writes each pooled pixel to the feature-map memory at a sequential address. One instance processes one feature map per `i_start`.

## Interface
- `OUT_W`, 26: conv output map width in pixels; must be even.
- `OUT_H`, 26: conv output map height in rows; must be even.
- `SUM_W`, 16: width of the signed conv sums.
- `SHIFT`, 4: right-shift applied before saturation to 8 bits.
- `ADDR_W`, 10: write-address width.

- `i_clk`, in, 1: single clock; all logic on the rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_start`, in, 1: one-cycle pulse that begins a map; honoured only in IDLE.
- `i_base_addr`, in, ADDR_W: first write address, latched on an accepted `i_start`.
- `i_valid`, in, 1: `i_sum1`/`i_sum2` are valid this cycle.
- `i_sum1`, in, SUM_W: signed sum for conv column 2k.
- `i_sum2`, in, SUM_W: signed sum for conv column 2k+1.
- `o_busy`, out, 1: high from accepted start until the final write.
- `o_wr_en`, out, 1: write strobe, one cycle per pooled pixel.
- `o_wr_addr`, out, ADDR_W: write address.
- `o_wr_data`, out, 8: pooled, requantised pixel.
- `o_done`, out, 1: one-cycle pulse coincident with the final `o_wr_en`.

## Operation
- Beats arrive in raster order.
  - Beat k of row r carries conv pixels (r, 2k) and (r, 2k+1).
  - Each row has OUT_W/2 beats; each map has OUT_H rows.
  - There is no backpressure; every `i_valid` beat is accepted.
- FSM has three states: IDLE, EVEN_ROW, ODD_ROW.
  - IDLE goes to EVEN_ROW on `i_start`. The transition latches `i_base_addr` and clears the column counter `col` (0..OUT_W/2-1) and the row counter `row` (0..OUT_H-1).
  - In EVEN_ROW, each beat does `pmax = max_signed(i_sum1, i_sum2)`, then `line_buf[col] <= pmax`. After the last beat of the row, go to ODD_ROW.
  - In ODD_ROW, each beat computes `m = max_signed(max_signed(i_sum1, i_sum2), line_buf[col])` and issues one write. After the last beat of the row:
    - if `row == OUT_H-1`, go to IDLE;
    - otherwise go to EVEN_ROW.
- Arithmetic:
  - `line_buf` is OUT_W/2 entries of SUM_W bits, signed. Its contents are not reset.
  - ReLU: `r = (m < 0) ? 0 : m`.
  - Requantisation: `q = r >>> SHIFT`. If `q > 255`, `o_wr_data = 255`; otherwise `o_wr_data = q[7:0]`.
- Addressing:
  - The first write goes to `i_base_addr`; each later write increments the address by 1.
  - A map produces (OUT_W/2)*(OUT_H/2) writes (169 at defaults), at addresses base..base+168.
  - The address wraps modulo 2^ADDR_W with no error flag.
- Boundary rules:
  - `i_valid` in IDLE is ignored.
  - `i_start` while busy is ignored.
  - `i_start` and `i_valid` in the same IDLE cycle: the start is taken and that beat is dropped.
  - Gaps in `i_valid` stall all counters; state is held indefinitely.
- Reset asserted mid-map: immediate return to IDLE. Counters are cleared and any pending output is discarded. The next map needs a new `i_start`.

## Timing
- Reset values: `o_busy`=0, `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_done`=0, state IDLE.
- `o_busy` rises the cycle after an accepted `i_start`. It falls the cycle after `o_done`.
- Write latency is 1 cycle. An ODD_ROW beat accepted at edge N gives `o_wr_en`/`o_wr_addr`/`o_wr_data` valid during cycle N+1.
  - `o_wr_en` is high for exactly one cycle per write.
  - `o_wr_addr` and `o_wr_data` hold their last values while `o_wr_en` is low.
- `o_done` is high in the same cycle as the 169th `o_wr_en`.
- The FSM is in IDLE in that same cycle, so an `i_start` in the `o_done` cycle is accepted.
- Peak throughput: one beat per cycle, one write per cycle during odd rows.

## Test plan
- **Reset:** hold `i_rst_n`=0 with random inputs -> all outputs 0. Release, then drive `i_valid` without `i_start` -> no writes, `o_busy`=0.
- **Uniform map:** start with base=100, stream 338 beats all sums = 256 -> 169 writes, data 16, addresses 100..268, `o_done` on the last write, `o_busy` low the next cycle.
- **Pool selection:** first even-row beat (160, 480), first odd-row beat (800, 320) -> first write data 50 at base. Negative map (all sums = -5) -> all data 0.
- **Saturation:** all sums 0x7FFF -> data 255. All sums 4095 -> data 255. All sums 4080 -> data 255. All sums 4079 -> data 254.
- **Gaps and ignored starts:**
  - Insert random `i_valid` gaps -> identical write sequence to the gapless run.
  - Pulse `i_start` with base=0 mid-map -> ignored, addresses unchanged.
- **Reset mid-map:** after 50 writes assert `i_rst_n` low for 1 cycle, then start with base=500 -> 169 fresh writes at 500..668, with no writes before the new start.
